sparc_mem_ctrl: RTL

Parametrised, byte-addressed, big-endian data memory with a multi-cycle MFC (memory-function-complete) handshake. Replaces the fixed 128x8-byte / 32-bit-port RAM used by the SPARC V8 datapath. Adds configurable depth and latency, SPARC op3-coded byte/halfword/word loads and stores, and load sign/zero extension. Sits between the MAR/MDR registers and the control unit, which waits on mfc.

---
 rtl/sparc_mem_pkg.sv | 13 +
 rtl/sparc_mem_ctrl_if.sv | 14 +
 rtl/mem_byte_array.sv | 23 ++
 rtl/sparc_mem_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg: shared op3 codes, FSM states and access-size encoding for the SPARC data memory
package sparc_mem_pkg;
   localparam logic [5:0] OP_LD   = 6'b000000;
   localparam logic [5:0] OP_LDUB = 6'b000001;
   localparam logic [5:0] OP_LDUH = 6'b000010;
   localparam logic [5:0] OP_ST   = 6'b000100;
   localparam logic [5:0] OP_STB  = 6'b000101;
   localparam logic [5:0] OP_STH  = 6'b000110;
   localparam logic [5:0] OP_LDSB = 6'b001001;
   localparam logic [5:0] OP_LDSH = 6'b001010;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
endpackage

// File: rtl/sparc_mem_ctrl_if.sv
// sparc_mem_ctrl_if: MAR/MDR request bus between the control unit (master) and the memory (slave)
//   enable, op_code, mar_addr, mdr_in : request from control unit
//   mdr_out, mfc, err                 : completion from memory
interface sparc_mem_ctrl_if #(parameter int ADDR_W = 7);
   logic              enable;
   logic [5:0]        op_code;
   logic [ADDR_W-1:0] mar_addr;
   logic [31:0]       mdr_in;
   logic [31:0]       mdr_out;
   logic              mfc;
   logic              err;
   modport master (output enable, op_code, mar_addr, mdr_in, input mdr_out, mfc, err);
   modport slave  (input enable, op_code, mar_addr, mdr_in, output mdr_out, mfc, err);
endinterface

// File: rtl/mem_byte_array.sv
// mem_byte_array: 2**ADDR_W x 8 storage with four byte lanes at addr+lane (wrapping)
//   clk   : write clock
//   we    : per-lane write enables, lane 0 = addr (bits 31:24 of wdata/rdata)
//   addr  : base byte address
//   wdata : big-endian lane data to write
//   rdata : combinational big-endian read of addr..addr+3
module mem_byte_array #(parameter int ADDR_W = 7) (
   input  logic              clk,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [7:0]        mem [2**ADDR_W];
   logic [ADDR_W-1:0] la  [4];
   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign la[g] = addr + ADDR_W'(g);
      assign rdata[31-8*g -: 8] = mem[la[g]];
   end
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[la[i]] <= wdata[31-8*i -: 8];
endmodule

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl: big-endian byte-addressed data memory with multi-cycle MFC handshake
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : sparc_mem_ctrl_if.slave (enable/op_code/mar_addr/mdr_in in; mdr_out/mfc/err out)
//   MEM_ALIGN_CHECK_EN : when defined, misaligned half/word accesses complete with err=1
module sparc_mem_ctrl
   import sparc_mem_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   sparc_mem_ctrl_if.slave       bus
);
   state_t            state;
   logic [3:0]        cnt;
   logic [5:0]        op_q, op;
   logic [ADDR_W-1:0] addr_q, addr;
   logic [31:0]       din_q, din, rdata, wdata, ext;
   logic [3:0]        mask, we;
   size_t             sz;
   logic              valid, ld, sgn, misal, bad, err_d, access;
   // with LATENCY=1 the access happens on the accepting edge, so decode the live bus
   assign op     = state == S_IDLE ? bus.op_code  : op_q;
   assign addr   = state == S_IDLE ? bus.mar_addr : addr_q;
   assign din    = state == S_IDLE ? bus.mdr_in   : din_q;
   assign access = (state == S_IDLE && bus.enable && LATENCY == 1) || (state == S_WAIT && cnt == 4'd0);
   always_comb begin
      valid = 1'b1;
      ld    = 1'b1;
      sgn   = 1'b0;
      sz    = SZ_WORD;
      unique case (op)
         OP_LD:   sz = SZ_WORD;
         OP_LDUB: sz = SZ_BYTE;
         OP_LDUH: sz = SZ_HALF;
         OP_LDSB: begin sz = SZ_BYTE; sgn = 1'b1; end
         OP_LDSH: begin sz = SZ_HALF; sgn = 1'b1; end
         OP_ST:   ld = 1'b0;
         OP_STB:  begin ld = 1'b0; sz = SZ_BYTE; end
         OP_STH:  begin ld = 1'b0; sz = SZ_HALF; end
         default: begin valid = 1'b0; ld = 1'b0; end
      endcase
   end
`ifdef MEM_ALIGN_CHECK_EN
   assign misal = (sz == SZ_HALF && addr[0]) || (sz == SZ_WORD && addr[1:0] != 2'b00);
   assign err_d = bad;
`else
   assign misal = 1'b0;
   assign err_d = 1'b0;
`endif
   assign bad   = !valid || misal;
   assign mask  = sz == SZ_WORD ? 4'b1111 : sz == SZ_HALF ? 4'b0011 : 4'b0001;
   assign wdata = sz == SZ_WORD ? din : sz == SZ_HALF ? {din[15:0], 16'h0} : {din[7:0], 24'h0};
   assign we    = access && !reset && !ld && !bad ? mask : 4'b0000;
   assign ext   = sz == SZ_WORD ? rdata
                : sz == SZ_HALF ? {{16{sgn & rdata[31]}}, rdata[31:16]}
                :                 {{24{sgn & rdata[31]}}, rdata[31:24]};
   mem_byte_array #(.ADDR_W(ADDR_W)) u_arr (
      .clk   (clk),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         bus.mdr_out <= 32'h0;
         bus.mfc     <= 1'b0;
         bus.err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.enable) begin
               op_q   <= bus.op_code;
               addr_q <= bus.mar_addr;
               din_q  <= bus.mdr_in;
               cnt    <= 4'(LATENCY - 1);
               state  <= S_WAIT;
            end
            S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            S_DONE: if (!bus.enable) begin
               state   <= S_IDLE;
               bus.mfc <= 1'b0;
               bus.err <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
         // stores leave mdr_out untouched; loads and faulted accesses update it
         if (access) begin
            state   <= S_DONE;
            bus.mfc <= 1'b1;
            bus.err <= err_d;
            if (ld || bad) bus.mdr_out <= bad ? 32'h0 : ext;
         end
      end
   end
endmodule
